// File: rtl/count_tracker_pkg.sv
// Shared types and helpers for the ripple-counter tracker.
// Holds the FSM state type, synchroniser depth and step arithmetic.
package count_tracker_pkg;

    typedef enum logic {
        INIT,
        TRACK
    } state_t;

    localparam int SYNC_STAGES = 2;

    function automatic logic [31:0] step_delta(
        input logic [31:0] q,
        input logic [31:0] c,
        input int          w
    );
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (c - q) & mask;
    endfunction

endpackage

// File: rtl/count_tracker_stab_filter.sv
// Synchroniser plus settle filter for the asynchronous ripple count.
// Presents a candidate value and a flag once it has been seen STABLE times.
module stab_filter #(
    parameter int W      = 4,
    parameter int STABLE = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] cand,
    output logic         stable
);
    import count_tracker_pkg::*;

    localparam int CW = $clog2(STABLE + 1);

    logic [W-1:0]           sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill;
    logic [CW-1:0]          scnt;

    // Reset zeros in the synchroniser are not real samples of O,
    // so the filter ignores them until the pipe has filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            fill <= '0;
            cand <= '0;
            scnt <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            fill <= {fill[SYNC_STAGES-2:0], 1'b1};
            if (fill[SYNC_STAGES-1]) begin
                if (sync_q[SYNC_STAGES-1] != cand) begin
                    cand <= sync_q[SYNC_STAGES-1];
                    scnt <= CW'(1);
                end else if (scnt != CW'(STABLE)) begin
                    scnt <= scnt + CW'(1);
                end
            end
        end
    end

    assign stable = (scnt == CW'(STABLE));

endmodule

// File: rtl/count_tracker.sv
// Tracks a glitchy ripple up/down counter and extends it with a wrap epoch.
// Classifies each settled change as up, down or illegal jump.
module count_tracker #(
    parameter int W      = 4,
    parameter int EXT    = 4,
    parameter int STABLE = 2
) (
    input  logic           C,
    input  logic           R,
    input  logic [W-1:0]   O,
    output logic [W-1:0]   Q,
    output logic [EXT-1:0] E,
    output logic           V,
    output logic           UP,
    output logic           WRAP,
    output logic           ERR
);
    import count_tracker_pkg::*;

    localparam logic [W-1:0] MAX  = '1;
    localparam logic [31:0]  D_UP = 32'd1;
    localparam logic [31:0]  D_DN = (32'd1 << W) - 32'd1;

    state_t       state;
    logic [W-1:0] cand;
    logic         stable;
    logic         accept;
    logic [31:0]  d;

    stab_filter #(
        .W      (W),
        .STABLE (STABLE)
    ) u_filt (
        .clk    (C),
        .rst    (R),
        .din    (O),
        .cand   (cand),
        .stable (stable)
    );

    assign d      = step_delta(32'(Q), 32'(cand), W);
    assign accept = stable && (state == INIT || cand != Q);

    always_ff @(posedge C) begin
        if (R) begin
            state <= INIT;
            Q     <= '0;
            E     <= '0;
            V     <= 1'b0;
            UP    <= 1'b0;
            WRAP  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            V    <= 1'b0;
            WRAP <= 1'b0;
            ERR  <= 1'b0;
            if (accept) begin
                Q <= cand;
                V <= 1'b1;
                case (state)
                    INIT: state <= TRACK;
                    TRACK: begin
                        unique case (1'b1)
                            (d == D_UP): begin
                                UP <= 1'b1;
                                if (Q == MAX && cand == '0) begin
                                    WRAP <= 1'b1;
                                    E    <= E + EXT'(1);
                                end
                            end
                            (d == D_DN): begin
                                UP <= 1'b0;
                                if (Q == '0 && cand == MAX) begin
                                    WRAP <= 1'b1;
                                    E    <= E - EXT'(1);
                                end
                            end
                            default: ERR <= 1'b1;
                        endcase
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_tracker.sv
// Self-checking bench for count_tracker: directed scenarios plus
// randomized stimulus against a sample-window reference model.
module tb_count_tracker;

    localparam int W      = 4;
    localparam int EXT    = 4;
    localparam int STABLE = 2;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic [3:0] O = 4'h0;
    logic [3:0] Q;
    logic [3:0] E;
    logic       V, UP, WRAP, ERR;

    int errors = 0;
    int checks = 0;

    logic [3:0] mq, me;
    logic       mv, mup, mwrap, merr;
    bit         mtrack;
    logic [3:0] hist[$];
    logic [3:0] cq[$];

    int dv_n, dw_n, de_n;

    count_tracker #(
        .W      (W),
        .EXT    (EXT),
        .STABLE (STABLE)
    ) dut (
        .C    (C),
        .R    (R),
        .O    (O),
        .Q    (Q),
        .E    (E),
        .V    (V),
        .UP   (UP),
        .WRAP (WRAP),
        .ERR  (ERR)
    );

    always #5 C = ~C;

    // Reference: a value is accepted once the last STABLE synchronised
    // samples (O seen two edges earlier, after reset) agree.
    task automatic step();
        logic [3:0] v;
        bit         ok;
        int         d;
        @(posedge C);
        if (R) begin
            mq = 0; me = 0; mv = 0; mup = 0; mwrap = 0; merr = 0;
            mtrack = 0;
            hist.delete();
            cq.delete();
        end else begin
            mv = 0; mwrap = 0; merr = 0;
            ok = (cq.size() >= STABLE);
            if (ok)
                for (int k = 1; k < STABLE; k++)
                    if (cq[cq.size()-1-k] != cq[cq.size()-1]) ok = 0;
            if (ok && (!mtrack || cq[cq.size()-1] != mq)) begin
                v  = cq[cq.size()-1];
                mv = 1;
                if (mtrack) begin
                    d = (int'(v) - int'(mq) + 16) % 16;
                    if (d == 1) begin
                        mup = 1;
                        if (v == 4'h0) begin mwrap = 1; me = me + 4'd1; end
                    end else if (d == 15) begin
                        mup = 0;
                        if (v == 4'hF) begin mwrap = 1; me = me - 4'd1; end
                    end else begin
                        merr = 1;
                    end
                end
                mq = v;
                mtrack = 1;
            end
            hist.push_back(O);
            if (hist.size() >= 3) begin
                cq.push_back(hist[hist.size()-3]);
                void'(hist.pop_front());
            end
            if (cq.size() > STABLE) void'(cq.pop_front());
        end
        #1;
    endtask

    task automatic clr_counts();
        dv_n = 0; dw_n = 0; de_n = 0;
    endtask

    task automatic hold(input logic [3:0] val, input int n);
        O = val;
        repeat (n) begin
            step();
            dv_n += int'(V);
            dw_n += int'(WRAP);
            de_n += int'(ERR);
        end
    endtask

    task automatic test_reset();
        R = 1'b1; O = 4'h9;
        step();
        checks++;
        if ({Q, E, V, UP, WRAP, ERR} !== 12'h0) begin
            errors++;
            $display("FAIL reset_state: got Q=%h E=%h V=%b UP=%b W=%b ERR=%b exp all 0",
                     Q, E, V, UP, WRAP, ERR);
        end
        R = 1'b0;
        repeat (4) begin
            step();
            checks++;
            if (V !== 1'b0) begin
                errors++;
                $display("FAIL reset_early_v: got V=%b exp 0", V);
            end
        end
        step();
        checks++;
        if ({V, Q, E, ERR, WRAP} !== {1'b1, 4'h9, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL first_accept: got V=%b Q=%h E=%h ERR=%b W=%b exp V=1 Q=9 E=0 ERR=0 W=0",
                     V, Q, E, ERR, WRAP);
        end
        step();
        checks++;
        if (V !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: got V=%b exp 0", V);
        end
    endtask

    task automatic test_up_wrap();
        for (int v = 10; v <= 14; v++) hold(4'(v), 8);
        clr_counts();
        hold(4'hF, 8);
        hold(4'h0, 8);
        checks++;
        if (dv_n != 2 || dw_n != 1 || de_n != 0) begin
            errors++;
            $display("FAIL up_wrap_pulses: got v=%0d w=%0d e=%0d exp 2 1 0",
                     dv_n, dw_n, de_n);
        end
        checks++;
        if ({Q, E, UP} !== {4'h0, 4'h1, 1'b1}) begin
            errors++;
            $display("FAIL up_wrap_state: got Q=%h E=%h UP=%b exp Q=0 E=1 UP=1",
                     Q, E, UP);
        end
    endtask

    task automatic test_down_wrap();
        clr_counts();
        hold(4'hF, 8);
        checks++;
        if ({Q, E, UP} !== {4'hF, 4'h0, 1'b0} || dw_n != 1 || dv_n != 1) begin
            errors++;
            $display("FAIL down_wrap1: got Q=%h E=%h UP=%b w=%0d v=%0d exp F 0 0 1 1",
                     Q, E, UP, dw_n, dv_n);
        end
        clr_counts();
        for (int v = 14; v >= 0; v--) hold(4'(v), 8);
        checks++;
        if ({Q, E} !== {4'h0, 4'h0} || de_n != 0 || dw_n != 0 || dv_n != 15) begin
            errors++;
            $display("FAIL down_walk: got Q=%h E=%h e=%0d w=%0d v=%0d exp 0 0 0 0 15",
                     Q, E, de_n, dw_n, dv_n);
        end
        clr_counts();
        hold(4'hF, 8);
        checks++;
        if ({Q, E, UP} !== {4'hF, 4'hF, 1'b0} || dw_n != 1) begin
            errors++;
            $display("FAIL down_wrap2: got Q=%h E=%h UP=%b w=%0d exp F F 0 1",
                     Q, E, UP, dw_n);
        end
    endtask

    task automatic test_jump();
        for (int v = 0; v <= 3; v++) hold(4'(v), 8);
        checks++;
        if ({Q, E, UP} !== {4'h3, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL jump_setup: got Q=%h E=%h UP=%b exp 3 0 1", Q, E, UP);
        end
        clr_counts();
        hold(4'h7, 8);
        checks++;
        if ({Q, E, UP} !== {4'h7, 4'h0, 1'b1} || de_n != 1 || dv_n != 1 || dw_n != 0) begin
            errors++;
            $display("FAIL jump_err: got Q=%h E=%h UP=%b e=%0d v=%0d w=%0d exp 7 0 1 1 1 0",
                     Q, E, UP, de_n, dv_n, dw_n);
        end
        clr_counts();
        hold(4'h8, 8);
        checks++;
        if ({Q, UP} !== {4'h8, 1'b1} || de_n != 0 || dv_n != 1) begin
            errors++;
            $display("FAIL jump_resync: got Q=%h UP=%b e=%0d v=%0d exp 8 1 0 1",
                     Q, UP, de_n, dv_n);
        end
    endtask

    task automatic test_glitch();
        hold(4'h7, 8);
        clr_counts();
        hold(4'hF, 1);
        hold(4'h8, 10);
        checks++;
        if (Q !== 4'h8 || UP !== 1'b1 || dv_n != 1 || de_n != 0) begin
            errors++;
            $display("FAIL glitch: got Q=%h UP=%b v=%0d e=%0d exp 8 1 1 0",
                     Q, UP, dv_n, de_n);
        end
    endtask

    task automatic test_mid_reset();
        O = 4'h9;
        repeat (3) step();
        R = 1'b1;
        step();
        R = 1'b0;
        checks++;
        if ({Q, E, V, UP, WRAP, ERR} !== 12'h0) begin
            errors++;
            $display("FAIL mid_reset_state: got Q=%h E=%h V=%b UP=%b W=%b ERR=%b exp all 0",
                     Q, E, V, UP, WRAP, ERR);
        end
        clr_counts();
        hold(4'h9, 8);
        checks++;
        if (Q !== 4'h9 || dv_n != 1 || dw_n != 0 || de_n != 0) begin
            errors++;
            $display("FAIL mid_reset_reaccept: got Q=%h v=%0d w=%0d e=%0d exp 9 1 0 0",
                     Q, dv_n, dw_n, de_n);
        end
    endtask

    task automatic test_random();
        logic [3:0] nv;
        int         n, mode;
        for (int it = 0; it < 300; it++) begin
            mode = $urandom_range(0, 19);
            nv   = O;
            n    = $urandom_range(3, 9);
            if (mode == 0) begin
                R = 1'b1;
                n = 1;
            end else if (mode <= 3) begin
                nv = 4'($urandom_range(0, 15));
            end else if (mode <= 5) begin
                nv = 4'($urandom_range(0, 15));
                n  = $urandom_range(1, 2);
            end else if (mode <= 12) begin
                nv = O + 4'd1;
            end else begin
                nv = O - 4'd1;
            end
            O = nv;
            repeat (n) begin
                step();
                checks++;
                if ({Q, E, V, UP, WRAP, ERR} !== {mq, me, mv, mup, mwrap, merr}) begin
                    errors++;
                    $display("FAIL random it%0d: got Q=%h E=%h V=%b UP=%b W=%b ERR=%b exp Q=%h E=%h V=%b UP=%b W=%b ERR=%b",
                             it, Q, E, V, UP, WRAP, ERR, mq, me, mv, mup, mwrap, merr);
                end
            end
            R = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_jump();
        test_glitch();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
